log_axi_read_bridge: RTL and testbench
======================================

Name: log_axi_read_bridge

Overview:
- AXI4-Lite read master that serves the single-word memory-read request interface driven by the CFI/DFI log arbiter (address + read trigger in; value, done, error out).
- Converts each request into one AR/R transaction toward the log memory interconnect and returns the 32-bit word.
- Bounds transaction time with a timeout and keeps the AXI side protocol-legal after a request is abandoned.

Parameters:
- ADDR_WIDTH, 32, width of request address and m_axi_araddr
- DATA_WIDTH, 32, width of read data (only 32 supported)
- ADDR_OFFSET, 32'h0000_0000, constant added (modulo 2^ADDR_WIDTH) to the request address to form araddr
- TIMEOUT_CYCLES, 256, cycles allowed in AR+R phases before error; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous active-low reset
- i_mem_addr  in  ADDR_WIDTH  request word address, sampled on trigger edge
- i_read_trigger  in  1  request; rising edge starts a read
- o_mem_value  out  DATA_WIDTH  read data; valid when o_done=1, held until next completion
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  one-cycle pulse coincident with o_done on failed read
- o_busy  out  1  high from accepted edge until return to IDLE (includes DRAIN)
- m_axi_araddr  out  ADDR_WIDTH  AXI read address
- m_axi_arprot  out  3  constant 3'b000
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  DATA_WIDTH  R data
- m_axi_rresp  in  2  R response
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; o_mem_value=0, o_done=0, o_error=0, o_busy=0, araddr=0, arvalid=0, rready=0, timeout counter=0, trigger-history register=1 (a trigger already high at reset release does not start a read). A read in flight is dropped with no done pulse.
- Edge detect: start = i_read_trigger & ~trig_q; trig_q updates every cycle in every state.
- IDLE: on start, capture araddr = i_mem_addr + ADDR_OFFSET, go to AR. arvalid is asserted in the next cycle.
- AR: arvalid=1, araddr stable. On arvalid&arready go to R.
- R: rready=1. On rvalid&rready: latch result and go to DONE.
  - rresp=2'b00: o_mem_value = rdata.
  - rresp=01/10/11: o_mem_value = 0 and flag error.
- DONE (1 cycle): o_done=1, o_error=flag; then IDLE. A new edge may be accepted in the DONE cycle, entering AR directly.
- Minimum latency with arready and rvalid tied high: edge sampled at cycle T, arvalid high at T+1, R handshake at T+2, o_done at T+3.
- Timeout: the counter clears on entry to AR and increments each cycle in AR or R.
  - When it reaches TIMEOUT_CYCLES without an R handshake, pulse o_done=1, o_error=1, o_mem_value=0 the next cycle, and go to DRAIN.
  - If the R handshake and expiry fall in the same cycle, the handshake wins (normal completion).
- DRAIN: finish the abandoned transaction legally. Keep arvalid=1 until the AR handshake if it has not happened; then rready=1 until the R handshake. Discard the data, assert no done, go to IDLE. o_busy stays high.
- Edges arriving in AR/R/DRAIN are ignored and not queued; the requester waits for o_done.
- arvalid never deasserts before arready. araddr is constant while arvalid=1. rready=0 outside R/DRAIN.

Test Plan:
- Basic read: addr=0x04, ADDR_OFFSET=0x1000_0000, arready=1, rvalid two cycles after AR handshake with rdata=0xFF, rresp=0 -> araddr=0x1000_0004; o_done pulses for one cycle with o_mem_value=0xFF and o_error=0; o_mem_value holds 0xFF afterwards.
- Slave error: rresp=2'b10, rdata=0xDEAD -> o_done=1, o_error=1, o_mem_value=0 for the same cycle.
- Backpressure: arready low for 5 cycles -> arvalid and araddr stable throughout; exactly one AR handshake; o_done follows the R handshake by one cycle.
- Timeout: TIMEOUT_CYCLES=8, rvalid withheld -> o_done+o_error 8 cycles after AR entry; o_busy stays high; later rvalid completes the drain with no second o_done; o_busy=0 afterwards.
- Trigger handling: trigger held high for 4 cycles -> one transaction; a second edge while busy is ignored; trigger high during reset release -> no transaction.
- Reset mid-read: rst low during R -> all outputs 0 immediately; after release with a new edge, a normal read returns correct data.

Source files
------------

// File: rtl/log_axi_read_bridge.sv
// AXI4-Lite read master for the CFI/DFI log arbiter: one single-word AR/R
// transaction per trigger edge, with a bounded wait and a legal drain of abandoned reads.
module log_axi_read_bridge #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET    = '0,
   parameter int                    TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   input  logic                  i_read_trigger,
   output logic [DATA_WIDTH-1:0] o_mem_value,
   output logic                  o_done,
   output logic                  o_error,
   output logic                  o_busy,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit               TMO_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   araddr_reg;
   logic                    arvalid_reg;
   logic                    rready_reg;
   logic [DATA_WIDTH-1:0]   mem_value_reg;
   logic                    done_reg;
   logic                    error_reg;
   logic                    busy_reg;
   logic                    trig_q;
   logic [CNT_W-1:0]        tmo_cnt_reg;

   logic start;
   logic ar_hs;
   logic r_hs;
   logic expire;

   always_comb begin
      start  = i_read_trigger & ~trig_q;
      ar_hs  = arvalid_reg & m_axi_arready;
      r_hs   = rready_reg & m_axi_rvalid;
      expire = TMO_EN && (tmo_cnt_reg == TMO_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         araddr_reg    <= '0;
         arvalid_reg   <= 1'b0;
         rready_reg    <= 1'b0;
         mem_value_reg <= '0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         trig_q        <= 1'b1;
         tmo_cnt_reg   <= '0;
      end else begin
         trig_q    <= i_read_trigger;
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         case (state_reg)
            // DONE shares IDLE's acceptance so back-to-back requests skip a dead cycle
            S_IDLE, S_DONE: begin
               if (start) begin
                  araddr_reg  <= i_mem_addr + ADDR_OFFSET;
                  arvalid_reg <= 1'b1;
                  tmo_cnt_reg <= '0;
                  busy_reg    <= 1'b1;
                  state_reg   <= S_AR;
               end else begin
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            S_AR, S_R: begin
               if (ar_hs) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
               end
               // A handshake on the expiry cycle still completes normally
               if (r_hs) begin
                  rready_reg    <= 1'b0;
                  mem_value_reg <= (m_axi_rresp == 2'b00) ? m_axi_rdata : '0;
                  error_reg     <= (m_axi_rresp != 2'b00);
                  done_reg      <= 1'b1;
                  state_reg     <= S_DONE;
               end else if (expire) begin
                  mem_value_reg <= '0;
                  error_reg     <= 1'b1;
                  done_reg      <= 1'b1;
                  state_reg     <= S_DRAIN;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                  if (ar_hs) begin
                     state_reg <= S_R;
                  end
               end
            end
            S_DRAIN: begin
               // Finish whichever half of the abandoned transaction is still open
               if (ar_hs) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
               end
               if (r_hs) begin
                  rready_reg <= 1'b0;
                  busy_reg   <= 1'b0;
                  state_reg  <= S_IDLE;
               end
            end
            default: begin
               arvalid_reg <= 1'b0;
               rready_reg  <= 1'b0;
               busy_reg    <= 1'b0;
               state_reg   <= S_IDLE;
            end
         endcase
      end
   end

   assign o_mem_value   = mem_value_reg;
   assign o_done        = done_reg;
   assign o_error       = error_reg;
   assign o_busy        = busy_reg;
   assign m_axi_araddr  = araddr_reg;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_reg;
   assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_log_axi_read_bridge.sv
// Directed bench for log_axi_read_bridge: scripted AXI slave, scoreboard of
// expected completions, protocol stability checks.
module tb_log_axi_read_bridge;
   localparam int          AW  = 32;
   localparam int          DW  = 32;
   localparam int          TMO = 8;
   localparam logic [31:0] OFS = 32'h1000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] i_mem_addr;
   logic          i_read_trigger;
   logic [DW-1:0] o_mem_value;
   logic          o_done, o_error, o_busy;
   logic [AW-1:0] m_axi_araddr;
   logic [2:0]    m_axi_arprot;
   logic          m_axi_arvalid, m_axi_arready;
   logic [DW-1:0] m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rvalid, m_axi_rready;

   always #5 clk = ~clk;

   log_axi_read_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_OFFSET(OFS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .i_mem_addr(i_mem_addr), .i_read_trigger(i_read_trigger),
      .o_mem_value(o_mem_value), .o_done(o_done), .o_error(o_error), .o_busy(o_busy),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   typedef struct {
      logic [31:0] value;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0, failures = 0;
   int   done_count = 0, ar_hs_count = 0, r_hs_count = 0;
   int   ar_wait = 0, r_wait = 0;
   bit   r_hold = 1'b0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_rresp = '0;
   int   ar_cnt = 0, r_cnt = 0;
   bit   r_pending = 1'b0, r_fire = 1'b0, ar_stalled = 1'b0;
   logic [31:0] stalled_addr = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave: decides ready/valid on the falling edge, so a handshake seen here
   // is the one the DUT samples on the next rising edge.
   initial begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            ar_cnt = 0; r_cnt = 0;
            r_pending = 1'b0; r_fire = 1'b0; ar_stalled = 1'b0;
         end else begin
            if (ar_stalled)
               check("ar_stable", {31'b0, m_axi_arvalid, m_axi_araddr}, {31'b0, 1'b1, stalled_addr});
            if (r_fire) begin
               m_axi_rvalid = 1'b0;
               r_fire = 1'b0;
            end else if (r_pending) begin
               if (!r_hold && r_cnt >= r_wait) begin
                  m_axi_rvalid = 1'b1;
                  m_axi_rdata  = s_rdata;
                  m_axi_rresp  = s_rresp;
               end else begin
                  m_axi_rvalid = 1'b0;
                  r_cnt++;
               end
               if (m_axi_rvalid && m_axi_rready) begin
                  r_fire = 1'b1;
                  r_pending = 1'b0;
                  r_hs_count++;
               end
            end
            if (m_axi_arvalid) begin
               if (ar_cnt >= ar_wait) begin
                  m_axi_arready = 1'b1;
                  ar_cnt = 0;
                  ar_hs_count++;
                  r_pending = 1'b1;
                  r_cnt = 0;
               end else begin
                  m_axi_arready = 1'b0;
                  ar_cnt++;
               end
            end else begin
               m_axi_arready = 1'b0;
            end
            ar_stalled   = m_axi_arvalid && !m_axi_arready;
            stalled_addr = m_axi_araddr;
         end
      end
   end

   // Completion monitor: every done pulse pops and checks one expectation.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (o_error)
            check("error_with_done", 64'(o_done), 64'd1);
         if (o_done) begin
            done_count++;
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               $display("done: value=%08h error=%0b expected value=%08h error=%0b",
                        o_mem_value, o_error, mon_e.value, mon_e.err);
               check("done_value", 64'(o_mem_value), 64'(mon_e.value));
               check("done_error", 64'(o_error), 64'(mon_e.err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, input int base, output int waited);
      waited = 0;
      while (done_count == base && waited < budget) begin
         tick();
         waited++;
      end
      check("done_seen", 64'(done_count != base), 64'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input bit timeout, output int lat);
      exp_t        e;
      int          base, w;
      logic [31:0] exp_addr;
      s_rdata  = data;
      s_rresp  = resp;
      exp_addr = addr + OFS;
      e.value  = (timeout || resp != 2'b00) ? 32'h0 : data;
      e.err    = timeout || (resp != 2'b00);
      sb.push_back(e);
      base = done_count;
      i_mem_addr = addr;
      i_read_trigger = 1'b1;
      tick();
      i_read_trigger = 1'b0;
      check("start_arvalid_busy", 64'({m_axi_arvalid, o_busy}), 64'b11);
      check("araddr", 64'(m_axi_araddr), 64'(exp_addr));
      wait_done(40, base, w);
      lat = 1 + w;
      $display("read: addr=%08h araddr=%08h resp=%0d latency=%0d", addr, exp_addr, resp, lat);
   endtask

   initial begin
      int          lat, base, bar, brh;
      logic [1:0]  resps [3];
      logic [31:0] datas [3];
      resps = '{2'b01, 2'b10, 2'b11};
      datas = '{32'h0000_BEEF, 32'h0000_DEAD, 32'hFFFF_FFFF};

      i_mem_addr = '0;
      i_read_trigger = 1'b1;
      repeat (2) tick();
      check("reset_outputs", 64'({o_done, o_error, o_busy, m_axi_arvalid, m_axi_rready, o_mem_value}), 64'd0);
      check("reset_araddr", 64'(m_axi_araddr), 64'd0);

      // Trigger already high across reset release must not start a read
      rst = 1'b1;
      repeat (3) tick();
      check("no_read_after_reset", 64'({o_busy, m_axi_arvalid}), 64'd0);
      check("no_ar_after_reset", 64'(ar_hs_count), 64'd0);
      i_read_trigger = 1'b0;
      tick();
      check("arprot", 64'(m_axi_arprot), 64'd0);

      // Basic read with two-cycle R delay
      ar_wait = 0; r_wait = 2;
      do_read(32'h0000_0004, 32'h0000_00FF, 2'b00, 1'b0, lat);
      tick();
      check("done_one_cycle", 64'(o_done), 64'd0);
      check("value_hold", 64'(o_mem_value), 64'h0000_00FF);
      check("busy_idle", 64'(o_busy), 64'd0);

      // Minimum latency and address wrap modulo 2^32
      r_wait = 0;
      do_read(32'hF000_0008, 32'hCAFE_0001, 2'b00, 1'b0, lat);
      check("min_latency", 64'(lat), 64'd3);

      // Slave error responses, issued back to back from the DONE cycle
      for (int i = 0; i < 3; i++)
         do_read(32'h0000_0100 + 32'(i * 4), datas[i], resps[i], 1'b0, lat);

      // AR backpressure for five cycles
      ar_wait = 5;
      bar = ar_hs_count;
      do_read(32'h0000_0020, 32'h5555_AAAA, 2'b00, 1'b0, lat);
      check("backpressure_latency", 64'(lat), 64'd8);
      check("backpressure_one_ar", 64'(ar_hs_count - bar), 64'd1);
      ar_wait = 0;
      repeat (2) tick();

      // Timeout with R withheld, then a late R completes the drain silently
      r_hold = 1'b1;
      base = done_count;
      do_read(32'h0000_0030, 32'h0000_0777, 2'b00, 1'b1, lat);
      check("timeout_latency", 64'(lat), 64'd9);
      repeat (4) tick();
      check("drain_busy", 64'(o_busy), 64'd1);
      check("drain_rready", 64'(m_axi_rready), 64'd1);
      brh = r_hs_count;
      r_hold = 1'b0;
      repeat (3) tick();
      check("drain_done_idle", 64'(o_busy), 64'd0);
      check("drain_no_second_done", 64'(done_count - base), 64'd1);
      check("drain_r_handshake", 64'(r_hs_count - brh), 64'd1);

      // Held trigger gives one read; an edge while busy is dropped
      base = done_count;
      bar = ar_hs_count;
      r_wait = 3;
      s_rdata = 32'h0000_1111;
      s_rresp = 2'b00;
      sb.push_back('{32'h0000_1111, 1'b0});
      i_mem_addr = 32'h0000_0040;
      i_read_trigger = 1'b1;
      repeat (4) tick();
      i_read_trigger = 1'b0;
      tick();
      check("busy_during_read", 64'(o_busy), 64'd1);
      i_read_trigger = 1'b1;
      tick();
      i_read_trigger = 1'b0;
      repeat (6) tick();
      check("held_trigger_one_done", 64'(done_count - base), 64'd1);
      check("held_trigger_one_ar", 64'(ar_hs_count - bar), 64'd1);
      check("held_trigger_idle", 64'(o_busy), 64'd0);
      $display("trigger: held edge and busy edge produced %0d completion(s)", done_count - base);

      // Reset in the middle of the R phase
      r_wait = 0;
      r_hold = 1'b1;
      i_mem_addr = 32'h0000_0050;
      i_read_trigger = 1'b1;
      tick();
      i_read_trigger = 1'b0;
      repeat (3) tick();
      check("mid_read_rready", 64'({o_busy, m_axi_rready}), 64'b11);
      base = done_count;
      rst = 1'b0;
      #1;
      check("async_reset_outputs",
            64'({o_done, o_error, o_busy, m_axi_arvalid, m_axi_rready, o_mem_value}), 64'd0);
      check("async_reset_araddr", 64'(m_axi_araddr), 64'd0);
      r_hold = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check("no_done_from_dropped", 64'(done_count - base), 64'd0);
      do_read(32'h0000_0060, 32'h1234_5678, 2'b00, 1'b0, lat);
      check("post_reset_latency", 64'(lat), 64'd3);
      repeat (2) tick();
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
